// File: rtl/usart_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the shared USART TX byte port.
// The arbiter connects through the slave modport; the requesters/transmitter side uses master.
interface usart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ*8-1:0]         req_data;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_last;
  logic [NUM_REQ-1:0]           req_ready;
  logic [7:0]                   tx_data;
  logic                         tx_send;
  logic                         tx_busy;
  logic [NUM_REQ-1:0]           grant;
  logic [$clog2(NUM_REQ)-1:0]   grant_id;

  modport master (
    output req_data, req_valid, req_last, tx_busy,
    input  req_ready, tx_data, tx_send, grant, grant_id
  );

  modport slave (
    input  req_data, req_valid, req_last, tx_busy,
    output req_ready, tx_data, tx_send, grant, grant_id
  );
endinterface

// File: rtl/usart_tx_arbiter.sv
// Round-robin arbiter sharing one USART transmitter among NUM_REQ byte streams,
// locking the owner until its last byte is sent or it stalls past LOCK_TIMEOUT.
module usart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                 comm_clock,
  input  logic                 reset,
  usart_tx_arbiter_if.slave    bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int TW  = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_MAX = TW'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACCEPT, WAIT_DONE} state_t;

  state_t               r_state, w_next;
  logic [IDW-1:0]       r_ptr, r_gid, w_sel, w_gid_inc;
  logic [NUM_REQ-1:0]   r_grant, w_ready_vec;
  logic [7:0]           r_tx_data;
  logic                 r_tx_send, r_last;
  logic [TW-1:0]        r_tmo;
  logic                 w_any, w_own_valid, w_ready, w_hs, w_release, w_tmo_inc;
  int                   j;

  assign w_own_valid = bus.req_valid[r_gid];
  assign w_ready     = (r_state == SEND) && !bus.tx_busy;
  assign w_hs        = w_ready && w_own_valid;
  assign w_gid_inc   = (r_gid == IDW'(NUM_REQ - 1)) ? '0 : r_gid + 1'b1;

  // Scan downward so the requester closest above the pointer is the last writer and wins.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    j     = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = int'(r_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (bus.req_valid[j]) begin
        w_any = 1'b1;
        w_sel = IDW'(j);
      end
    end
  end

  always_comb begin
    w_ready_vec = '0;
    if (w_ready) w_ready_vec[r_gid] = 1'b1;
  end

  always_ff @(posedge comm_clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_release = 1'b0;
    w_tmo_inc = 1'b0;
    case (r_state)
      IDLE:        if (w_any) w_next = SEND;
      SEND: begin
        if (w_hs) w_next = WAIT_ACCEPT;
        else if (!w_own_valid) begin
          if (r_tmo == TMO_MAX) begin
            w_release = 1'b1;
            w_next    = IDLE;
          end else begin
            w_tmo_inc = 1'b1;
          end
        end
      end
      WAIT_ACCEPT: if (bus.tx_busy) w_next = WAIT_DONE;
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (r_last) begin
            w_release = 1'b1;
            w_next    = IDLE;
          end else begin
            w_next    = SEND;
          end
        end
      end
      default:     w_next = IDLE;
    endcase
  end

  always_ff @(posedge comm_clock or posedge reset) begin
    if (reset) begin
      r_ptr     <= '0;
      r_gid     <= '0;
      r_grant   <= '0;
      r_tx_data <= '0;
      r_tx_send <= 1'b0;
      r_last    <= 1'b0;
      r_tmo     <= '0;
    end else begin
      r_tx_send <= w_hs;
      if (r_state == IDLE && w_any) begin
        r_grant <= NUM_REQ'(1) << w_sel;
        r_gid   <= w_sel;
      end
      if (w_release) begin
        r_grant <= '0;
        r_ptr   <= w_gid_inc;
        r_tmo   <= '0;
      end
      if (w_hs) begin
        r_tx_data <= bus.req_data[{r_gid, 3'b000} +: 8];
        r_last    <= bus.req_last[r_gid];
        r_tmo     <= '0;
      end
      if (w_tmo_inc) r_tmo <= r_tmo + 1'b1;
    end
  end

  assign bus.req_ready = w_ready_vec;
  assign bus.tx_data   = r_tx_data;
  assign bus.tx_send   = r_tx_send;
  assign bus.grant     = r_grant;
  assign bus.grant_id  = r_gid;
endmodule
